lr_pkt_loader: RTL and testbench
================================

LR_PKT_LOADER -- requirements
Module: lr_pkt_loader

Interface
REQ-001 SHALL have parameter BASE_W, default 12, giving the word-address width matching the 16 KB local RAM address addr[13:2].
REQ-002 SHALL have ports, in this order:
  clk  in  1  single clock; all logic on its rising edge.
  reset  in  1  asynchronous, active-high reset.
  arm  in  1  one-cycle pulse that starts a load into the local RAM.
  base_addr  in  12  first word address of the buffer; sampled on arm.
  rx_data  in  8  received byte.
  rx_valid  in  1  rx_data is valid.
  rx_sop  in  1  first byte of packet; qualified by rx_valid.
  rx_eop  in  1  last byte of packet; qualified by rx_valid.
  rx_ready  out  1  loader accepts a byte this cycle.
  addr  out  12  RAM word address, addr[13:2].
  data_in  out  32  RAM write data.
  we  out  4  RAM byte-lane write enables.
  en  out  1  RAM clock enable.
  busy  out  1  load in progress.
  done  out  1  one-cycle completion pulse.
  overflow  out  1  sticky: packet exceeded buffer space.
  byte_count  out  14  bytes stored for the current or last packet.

Function
REQ-003 SHALL implement states IDLE, ARMED, RECV, FLUSH, HDR and DONE.
REQ-004 SHALL move IDLE->ARMED on arm, latching base_addr, clearing byte_count and overflow, and setting busy=1.
REQ-005 SHALL ignore arm in every state except IDLE.
REQ-006 SHALL drive rx_ready=1 in ARMED and RECV and 0 in all other states; a byte is accepted when rx_valid & rx_ready.
REQ-007 SHALL, in ARMED, discard accepted bytes without rx_sop; a byte accepted with rx_sop SHALL be stored as byte 0 and the FSM SHALL enter RECV.
REQ-008 SHALL treat rx_sop in RECV as ordinary data.
REQ-009 SHALL pack bytes little-endian: byte n goes to lane n mod 4, i.e. data_in[8*(n mod 4)+7 : 8*(n mod 4)].
REQ-010 SHALL issue a write when lane 3 is filled, with we=4'hF, en=1, and addr equal to the current word pointer; the pointer SHALL then increment.
REQ-011 SHALL register write outputs: a write SHALL be visible in the cycle immediately after the edge that accepted its last byte, with en=1 for exactly that one cycle.
REQ-012 SHALL, on an eop byte, write any partial word in the next cycle with we set only for the filled lanes (e.g. 2 bytes -> 4'b0011) and enter FLUSH; if eop fills lane 3 there SHALL be exactly one write with we=4'hF.
REQ-013 SHALL drive we=0 and en=1'b0 in every cycle without a write; unused data_in lanes are don't-care.
REQ-014 SHALL increment byte_count once per stored byte.
REQ-015 SHALL, when the word pointer would pass 12'hFFF, suppress all further writes, set overflow=1, and keep rx_ready=1 until eop so the packet is drained.
REQ-016 SHALL go FLUSH->HDR when the macro is defined, otherwise FLUSH->DONE.
REQ-017 SHALL assert done=1 for one cycle in DONE, clear busy, and return to IDLE.
REQ-018 SHALL NOT let the word pointer wrap to 0.

Reset
REQ-019 SHALL, on reset assertion, immediately and asynchronously force state=IDLE and all outputs to 0, including we, en, rx_ready, busy, done, overflow, byte_count and addr.
REQ-020 SHALL NOT complete or issue any partial-word write on a reset that arrives mid-packet.

Configuration
REQ-021 SHALL, with LR_LOADER_LEN_HDR_EN defined, store payload starting at base_addr+1 and, in HDR, write {18'b0, byte_count} to base_addr with we=4'hF; the capacity check SHALL include the header word.
REQ-022 SHALL, without LR_LOADER_LEN_HDR_EN, store payload from base_addr and have no HDR state or header write.

Verification
REQ-023 SHALL be verified with no macro, base 0, bytes 11 22 33 44 (sop/eop) -> one write, addr=0, data_in=0x44332211, we=F; done one cycle later; byte_count=4.
REQ-024 SHALL be verified with no macro, 6 bytes 11..66 -> write addr 0 we=F, then addr 1 we=0011 with data_in[15:0]=0x6655; byte_count=6.
REQ-025 SHALL be verified with the macro, base 0x010, 5 bytes -> writes at 0x011 (F) and 0x012 (0001), then 0x010 data=5 we=F, then done.
REQ-026 SHALL be verified with no macro, base 0xFFF, 8 bytes -> a single write at 0xFFF, overflow=1, byte_count=4, rx_ready held until eop, then done.
REQ-027 SHALL be verified with reset asserted after 2 bytes of a packet -> we=0, en=0, busy=0 immediately; no write occurs after reset release.
REQ-028 SHALL be verified with arm pulsed during RECV -> ignored; base address and count are unchanged.

Source files
------------

// File: rtl/lr_pkt_loader.sv
// Purpose: packs a sop..eop byte stream little-endian into 32-bit words and writes them to local RAM from base_addr.
// Latency: a word write appears the cycle after the edge that accepted its last byte; done follows the last write by one cycle.
// Backpressure: rx_ready is high in ARMED/RECV (an overflowing packet is still drained to eop) and low in all other states.
// Build option: LR_LOADER_LEN_HDR_EN reserves base_addr for a {18'b0, byte_count} length header word.
module lr_pkt_loader #(
    parameter int BASE_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic [BASE_W-1:0] base_addr,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_sop,
    input  logic              rx_eop,
    output logic              rx_ready,
    output logic [BASE_W-1:0] addr,
    output logic [31:0]       data_in,
    output logic [3:0]        we,
    output logic              en,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [13:0]       byte_count
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RECV,
        FLUSH,
`ifdef LR_LOADER_LEN_HDR_EN
        HDR,
`endif
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BASE_W-1:0] ptr;        // next payload word address
    logic              full;       // ptr already consumed the last RAM word
    logic              rx_st;
    logic              take;       // byte accepted and belongs to the packet
    logic [1:0]        lane;
    logic [3:0]        lane_mask;

`ifdef LR_LOADER_LEN_HDR_EN
    logic [BASE_W-1:0] base_q;     // header word location
`endif

    assign rx_st    = (state == ARMED) || (state == RECV);
    assign rx_ready = rx_st;
    // In ARMED only a sop byte opens the packet; everything else is dropped.
    assign take     = rx_valid && rx_st && ((state == RECV) || rx_sop);
    assign lane     = byte_count[1:0];
    assign busy     = (state != IDLE) && (state != DONE);
    assign done     = (state == DONE);

    // Lanes filled so far in the current word, including the incoming byte.
    always_comb begin
        lane_mask = 4'b0001;
        case (lane)
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            2'd2:    lane_mask = 4'b0111;
            default: lane_mask = 4'b1111;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm) state_nxt = ARMED;
            ARMED:   if (take) state_nxt = rx_eop ? FLUSH : RECV;
            RECV:    if (take && rx_eop) state_nxt = FLUSH;
`ifdef LR_LOADER_LEN_HDR_EN
            FLUSH:   state_nxt = HDR;
            HDR:     state_nxt = DONE;
`else
            FLUSH:   state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte packing, registered RAM write port, pointer and status counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            full       <= 1'b0;
            addr       <= '0;
            data_in    <= '0;
            we         <= '0;
            en         <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
`ifdef LR_LOADER_LEN_HDR_EN
            base_q     <= '0;
`endif
        end else begin
            we <= '0;
            en <= 1'b0;
            if ((state == IDLE) && arm) begin
                byte_count <= '0;
                overflow   <= 1'b0;
`ifdef LR_LOADER_LEN_HDR_EN
                base_q     <= base_addr;
                ptr        <= base_addr + BASE_W'(1);
                // Header at the top word leaves no room for payload.
                full       <= &base_addr;
`else
                ptr        <= base_addr;
                full       <= 1'b0;
`endif
            end
            if (take) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    data_in[{lane, 3'b000} +: 8] <= rx_data;
                    byte_count <= byte_count + 14'd1;
                    if ((lane == 2'd3) || rx_eop) begin
                        en   <= 1'b1;
                        we   <= lane_mask;
                        addr <= ptr;
                        // Saturate instead of wrapping to word 0.
                        if (lane == 2'd3) begin
                            if (&ptr) full <= 1'b1;
                            else      ptr  <= ptr + BASE_W'(1);
                        end
                    end
                end
            end
`ifdef LR_LOADER_LEN_HDR_EN
            if (state == FLUSH) begin
                en      <= 1'b1;
                we      <= 4'hF;
                addr    <= base_q;
                data_in <= {18'b0, byte_count};
            end
`endif
        end
    end

endmodule

// File: tb/tb_lr_pkt_loader.sv
`timescale 1ns/1ps
module tb_lr_pkt_loader;

`ifdef LR_LOADER_LEN_HDR_EN
    localparam int HDR_MODE = 1;
`else
    localparam int HDR_MODE = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic [11:0] base_addr = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_sop = 1'b0;
    logic        rx_eop = 1'b0;
    logic        rx_ready;
    logic [11:0] addr;
    logic [31:0] data_in;
    logic [3:0]  we;
    logic        en;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [13:0] byte_count;

    lr_pkt_loader #(.BASE_W(12)) dut (
        .clk(clk), .reset(reset), .arm(arm), .base_addr(base_addr),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_ready(rx_ready), .addr(addr), .data_in(data_in), .we(we), .en(en),
        .busy(busy), .done(done), .overflow(overflow), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [3:0]  we;
        logic [31:0] d;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [11:0] base;
        int          len;
        logic [7:0]  first;
        int          exp_cnt;
        int          exp_ovf;
        int          exp_nwr;
    } vec_t;

    wr_t        wlog[$];
    wr_t        exp_q[$];
    logic [7:0] pkt[$];
    int         exp_cnt;
    int         exp_ovf;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic       done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: logs RAM writes, checks idle write enables and done width.
    always @(negedge clk) begin
        if (en) wlog.push_back('{addr, we, data_in, cyc});
        n_chk++;
        if (!en && we !== 4'h0) begin
            n_fail++;
            $display("FAIL idle_we: got we=%h with en=0, want 0", we);
        end
        n_chk++;
        if (done && done_prev) begin
            n_fail++;
            $display("FAIL done_width: done high two cycles in a row at cycle %0d", cyc);
        end
        done_prev = done;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: capacity in words from the start address, bytes beyond it are dropped.
    task automatic model(input int base);
        int start, cap, stored, nw, lanes;
        wr_t e;
        exp_q.delete();
        start  = base + HDR_MODE;
        cap    = 4096 - start;
        stored = (pkt.size() < 4 * cap) ? pkt.size() : 4 * cap;
        exp_ovf = (pkt.size() > stored) ? 1 : 0;
        exp_cnt = stored;
        nw = (stored + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            lanes = stored - 4 * w;
            if (lanes > 4) lanes = 4;
            e.a   = 12'(start + w);
            e.we  = 4'((1 << lanes) - 1);
            e.d   = '0;
            e.cyc = 0;
            for (int k = 0; k < lanes; k++) e.d[8*k +: 8] = pkt[4*w + k];
            exp_q.push_back(e);
        end
        if (HDR_MODE != 0) begin
            e.a = 12'(base); e.we = 4'hF; e.d = 32'(stored); e.cyc = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic cmp_log(input string tag);
        logic [31:0] m;
        chk({tag, ".nwr"}, wlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            m = {{8{exp_q[i].we[3]}}, {8{exp_q[i].we[2]}}, {8{exp_q[i].we[1]}}, {8{exp_q[i].we[0]}}};
            chk({tag, ".addr"}, wlog[i].a, exp_q[i].a);
            chk({tag, ".we"}, wlog[i].we, exp_q[i].we);
            chk({tag, ".data"}, wlog[i].d & m, exp_q[i].d);
        end
        chk({tag, ".byte_count"}, byte_count, exp_cnt);
        chk({tag, ".overflow"}, overflow, exp_ovf);
    endtask

    task automatic do_arm(input logic [11:0] b);
        arm = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        arm = 1'b0;
        base_addr = 12'($urandom);
        chk("armed.busy", busy, 1);
    endtask

    task automatic send_pkt(input int gaps, input int junk);
        for (int j = 0; j < junk; j++) begin
            rx_valid = 1'b1; rx_data = 8'($urandom); rx_sop = 1'b0; rx_eop = 1'b0;
            @(posedge clk); #1;
        end
        for (int i = 0; i < pkt.size(); i++) begin
            if (gaps != 0 && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0; rx_data = 8'($urandom);
                rx_sop = 1'($urandom); rx_eop = 1'($urandom);
                @(posedge clk); #1;
            end
            rx_valid = 1'b1; rx_data = pkt[i];
            rx_sop = (i == 0); rx_eop = (i == pkt.size() - 1);
            chk("rx_ready", rx_ready, 1);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        bit seen;
        seen = 1'b0;
        dcyc = -1;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; dcyc = cyc; end
        end
        chk({tag, ".done_seen"}, seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_pkt(input string tag, input logic [11:0] b, input int gaps,
                           input int junk, output int dcyc);
        wlog.delete();
        do_arm(b);
        send_pkt(gaps, junk);
        wait_done(tag, dcyc);
        model(int'(b));
        cmp_log(tag);
    endtask

    vec_t vt[7];
    int   dc;

    initial begin
        // base, len, first byte, expected byte_count, overflow, write count
        vt[0] = '{12'h000, 1, 8'h10, 1, 0, 1 + HDR_MODE};
        vt[1] = '{12'h005, 4, 8'h20, 4, 0, 1 + HDR_MODE};
        vt[2] = '{12'h100, 7, 8'h30, 7, 0, 2 + HDR_MODE};
        vt[3] = '{12'h7FF, 9, 8'h40, 9, 0, 3 + HDR_MODE};
`ifdef LR_LOADER_LEN_HDR_EN
        vt[4] = '{12'hFFE, 8, 8'h50, 4, 1, 2};
        vt[5] = '{12'hFFF, 8, 8'h60, 0, 1, 1};
        vt[6] = '{12'hFFD, 12, 8'h70, 8, 1, 3};
`else
        vt[4] = '{12'hFFE, 8, 8'h50, 8, 0, 2};
        vt[5] = '{12'hFFF, 8, 8'h60, 4, 1, 1};
        vt[6] = '{12'hFFD, 12, 8'h70, 12, 0, 3};
`endif

        // Reset state
        #2;
        chk("rst.rx_ready", rx_ready, 0);
        chk("rst.addr", addr, 0);
        chk("rst.we", we, 0);
        chk("rst.en", en, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.overflow", overflow, 0);
        chk("rst.byte_count", byte_count, 0);
        #20 reset = 1'b0;
        @(posedge clk); #1;

        // Table vectors
        for (int v = 0; v < 7; v++) begin
            pkt.delete();
            for (int i = 0; i < vt[v].len; i++) pkt.push_back(8'(vt[v].first + i));
            run_pkt($sformatf("vec%0d", v), vt[v].base, 0, 0, dc);
            chk($sformatf("vec%0d.tbl_cnt", v), byte_count, vt[v].exp_cnt);
            chk($sformatf("vec%0d.tbl_ovf", v), overflow, vt[v].exp_ovf);
            chk($sformatf("vec%0d.tbl_nwr", v), wlog.size(), vt[v].exp_nwr);
            chk($sformatf("vec%0d.idle", v), busy, 0);
        end

`ifdef LR_LOADER_LEN_HDR_EN
        // Header build: payload after base, header last, then done
        pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_pkt("hdr5", 12'h010, 0, 0, dc);
        if (wlog.size() == 3) begin
            chk("hdr5.a0", wlog[0].a, 12'h011);
            chk("hdr5.d0", wlog[0].d, 32'h44332211);
            chk("hdr5.we1", wlog[1].we, 4'b0001);
            chk("hdr5.d1", wlog[1].d[7:0], 8'h55);
            chk("hdr5.ha", wlog[2].a, 12'h010);
            chk("hdr5.hd", wlog[2].d, 32'd5);
            chk("hdr5.done_lat", dc, wlog[2].cyc + 1);
        end
`else
        // Single aligned word, done one cycle after the write
        pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_pkt("w4", 12'h000, 0, 0, dc);
        if (wlog.size() == 1) begin
            chk("w4.addr", wlog[0].a, 12'h000);
            chk("w4.data", wlog[0].d, 32'h44332211);
            chk("w4.we", wlog[0].we, 4'hF);
            chk("w4.done_lat", dc, wlog[0].cyc + 1);
        end
        chk("w4.count", byte_count, 4);
        // Partial tail word
        pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_pkt("w6", 12'h000, 0, 0, dc);
        if (wlog.size() == 2) begin
            chk("w6.a1", wlog[1].a, 12'h001);
            chk("w6.we1", wlog[1].we, 4'b0011);
            chk("w6.d1", wlog[1].d[15:0], 16'h6655);
        end
        chk("w6.count", byte_count, 6);
`endif

        // Reset mid-packet: outputs drop at once, no tail write afterwards
        wlog.delete();
        do_arm(12'h040);
        rx_valid = 1'b1; rx_data = 8'hA1; rx_sop = 1'b1; rx_eop = 1'b0;
        @(posedge clk); #1;
        rx_data = 8'hB2; rx_sop = 1'b0;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst.we", we, 0);
        chk("mid_rst.en", en, 0);
        chk("mid_rst.busy", busy, 0);
        chk("mid_rst.rx_ready", rx_ready, 0);
        chk("mid_rst.byte_count", byte_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        rx_valid = 1'b1; rx_data = 8'hCC; rx_eop = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rx_valid = 1'b0; rx_eop = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_rst.no_write", wlog.size(), 0);
        chk("mid_rst.idle", busy, 0);

        // arm during RECV is ignored
        wlog.delete();
        pkt = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        do_arm(12'h020);
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = pkt[i]; rx_sop = (i == 0); rx_eop = (i == 3);
            arm = (i == 2); base_addr = 12'h300;
            @(posedge clk); #1;
        end
        arm = 1'b0; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        wait_done("arm_recv", dc);
        model(32'h020);
        cmp_log("arm_recv");

        // Randomized packets with gaps and leading junk
        for (int r = 0; r < 40; r++) begin
            logic [11:0] b;
            int          len;
            b = ($urandom_range(0, 3) == 0) ? 12'(12'hFF0 + $urandom_range(0, 15)) : 12'($urandom);
            len = $urandom_range(1, 20);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
            run_pkt($sformatf("rnd%0d", r), b, 1, $urandom_range(0, 2), dc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
